// File: rtl/mux_ctrl.sv
// MUX instruction executor: loads the crossbar switch chain and/or runs one SPI ADC
// conversion, then returns the 16-bit result on the direct-data port.
module mux_ctrl #(
   parameter int SW_BITS       = 22,
   parameter int SCLK_DIV      = 4,
   parameter int CNV_CYCLES    = 100,
   parameter int SETTLE_CYCLES = 50
) (
   input  logic        fpga_clk_i,
   input  logic        reset_n_i,
   input  logic [23:0] mux_ins_i,
   input  logic        mux_en_i,
   output logic        mux_idle_o,
   output logic        mux_data_ready_o,
   output logic [15:0] mux_data_o,
   output logic        ovr_o,
   output logic        sw_sclk_o,
   output logic        sw_sdo_o,
   output logic        sw_sync_n_o,
   output logic        adc_cnv_o,
   output logic        adc_sclk_o,
   input  logic        adc_sdo_i
);

   localparam int PH_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

   typedef enum logic [2:0] {IDLE, SW_SHIFT, SW_LATCH, SETTLE, CNV, ADC_SHIFT, DONE} state_t;
   typedef enum logic [1:0] {CMD_NOP, CMD_CONNECT, CMD_MEASURE, CMD_CONN_MEAS} cmd_t;

   state_t             state;
   cmd_t               cmd;
   cmd_t               new_cmd;
   logic [SW_BITS-1:0] sw_shift;
   logic [15:0]        adc_shift;
   logic [15:0]        adc_next;
   logic [4:0]         bit_cnt;
   logic [PH_W-1:0]    phase;
   logic [15:0]        delay;
   logic               phase_end;
   logic               can_accept;

   assign new_cmd    = cmd_t'(mux_ins_i[23:22]);
   assign phase_end  = (phase == PH_W'(SCLK_DIV - 1));
   assign can_accept = (state == IDLE) || (state == DONE);
   assign adc_next   = {adc_shift[14:0], adc_sdo_i};

   // NOTE: every register here, outputs included, is updated with <= so all reads in
   // this block see the pre-edge value and the final assignment in program order wins.
   always_ff @(posedge fpga_clk_i) begin
      if (!reset_n_i) begin
         state            <= IDLE;
         cmd              <= CMD_NOP;
         sw_shift         <= '0;
         adc_shift        <= '0;
         bit_cnt          <= '0;
         phase            <= '0;
         delay            <= '0;
         mux_idle_o       <= 1'b1;
         mux_data_ready_o <= 1'b0;
         mux_data_o       <= '0;
         ovr_o            <= 1'b0;
         sw_sclk_o        <= 1'b0;
         sw_sdo_o         <= 1'b0;
         sw_sync_n_o      <= 1'b1;
         adc_cnv_o        <= 1'b0;
         adc_sclk_o       <= 1'b0;
      end else begin
         mux_data_ready_o <= 1'b0;
         if (mux_en_i && !can_accept) ovr_o <= 1'b1;

         case (state)
            IDLE, DONE: begin
               state      <= IDLE;
               mux_idle_o <= 1'b1;
               if (mux_en_i) begin
                  cmd   <= new_cmd;
                  phase <= '0;
                  case (new_cmd)
                     CMD_CONNECT, CMD_CONN_MEAS: begin
                        state       <= SW_SHIFT;
                        mux_idle_o  <= 1'b0;
                        sw_sync_n_o <= 1'b0;
                        sw_sdo_o    <= mux_ins_i[SW_BITS-1];
                        sw_shift    <= {mux_ins_i[SW_BITS-2:0], 1'b0};
                        bit_cnt     <= 5'(SW_BITS - 1);
                     end
                     CMD_MEASURE: begin
                        state      <= CNV;
                        mux_idle_o <= 1'b0;
                        adc_cnv_o  <= 1'b1;
                        delay      <= 16'(CNV_CYCLES - 1);
                     end
                     default: ;
                  endcase
               end
            end

            // Data moves only on the falling sclk edge, so it is stable at the chip's rising edge.
            SW_SHIFT: begin
               if (phase_end) begin
                  phase <= '0;
                  if (!sw_sclk_o) begin
                     sw_sclk_o <= 1'b1;
                  end else begin
                     sw_sclk_o <= 1'b0;
                     if (bit_cnt == 5'd0) begin
                        state       <= SW_LATCH;
                        sw_sdo_o    <= 1'b0;
                        sw_sync_n_o <= 1'b1;
                     end else begin
                        bit_cnt  <= bit_cnt - 5'd1;
                        sw_sdo_o <= sw_shift[SW_BITS-1];
                        sw_shift <= sw_shift << 1;
                     end
                  end
               end else begin
                  phase <= phase + 1'b1;
               end
            end

            SW_LATCH: begin
               if (phase_end) begin
                  phase <= '0;
                  if (cmd == CMD_CONN_MEAS) begin
                     state <= SETTLE;
                     delay <= 16'(SETTLE_CYCLES - 1);
                  end else begin
                     state      <= IDLE;
                     mux_idle_o <= 1'b1;
                  end
               end else begin
                  phase <= phase + 1'b1;
               end
            end

            SETTLE: begin
               if (delay == 16'd0) begin
                  state     <= CNV;
                  adc_cnv_o <= 1'b1;
                  delay     <= 16'(CNV_CYCLES - 1);
               end else begin
                  delay <= delay - 16'd1;
               end
            end

            CNV: begin
               if (delay == 16'd0) begin
                  state     <= ADC_SHIFT;
                  adc_cnv_o <= 1'b0;
                  bit_cnt   <= 5'd15;
                  phase     <= '0;
               end else begin
                  delay <= delay - 16'd1;
               end
            end

            // The last bit is captured on the same edge that publishes the result.
            ADC_SHIFT: begin
               if (phase_end) begin
                  phase <= '0;
                  if (!adc_sclk_o) begin
                     adc_sclk_o <= 1'b1;
                  end else begin
                     adc_sclk_o <= 1'b0;
                     adc_shift  <= adc_next;
                     if (bit_cnt == 5'd0) begin
                        state            <= DONE;
                        mux_data_o       <= adc_next;
                        mux_data_ready_o <= 1'b1;
                        mux_idle_o       <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt - 5'd1;
                     end
                  end
               end else begin
                  phase <= phase + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_ctrl.sv
// Self-checking bench for mux_ctrl: switch-chain and ADC models feed a scoreboard of
// expected patterns/results with their due edges.
module tb_mux_ctrl;

   localparam int SW_BITS       = 22;
   localparam int SCLK_DIV      = 4;
   localparam int CNV_CYCLES    = 100;
   localparam int SETTLE_CYCLES = 50;
   localparam int D             = SCLK_DIV;

   typedef struct {
      logic [21:0] pat;
      int          due;
   } sw_exp_t;

   typedef struct {
      logic [15:0] data;
      int          due;
   } rd_exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [23:0] mux_ins = '0;
   logic        mux_en = 1'b0;
   logic        mux_idle;
   logic        mux_data_ready;
   logic [15:0] mux_data;
   logic        ovr;
   logic        sw_sclk;
   logic        sw_sdo;
   logic        sw_sync_n;
   logic        adc_cnv;
   logic        adc_sclk;
   logic        adc_sdo = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   sw_exp_t sw_q[$];
   rd_exp_t rd_q[$];

   logic [15:0] adc_word = '0;
   logic [15:0] adc_sr   = '0;
   logic [21:0] sw_cap   = '0;
   int          sw_cnt   = 0;
   int          adc_cnt  = 0;
   int          cnv_len  = 0;
   logic        prev_sw_sclk = 1'b0, prev_sync_n = 1'b1, prev_cnv = 1'b0, prev_adc_sclk = 1'b0;

   mux_ctrl #(
      .SW_BITS(SW_BITS), .SCLK_DIV(SCLK_DIV), .CNV_CYCLES(CNV_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES)
   ) dut (
      .fpga_clk_i       (clk),
      .reset_n_i        (reset_n),
      .mux_ins_i        (mux_ins),
      .mux_en_i         (mux_en),
      .mux_idle_o       (mux_idle),
      .mux_data_ready_o (mux_data_ready),
      .mux_data_o       (mux_data),
      .ovr_o            (ovr),
      .sw_sclk_o        (sw_sclk),
      .sw_sdo_o         (sw_sdo),
      .sw_sync_n_o      (sw_sync_n),
      .adc_cnv_o        (adc_cnv),
      .adc_sclk_o       (adc_sclk),
      .adc_sdo_i        (adc_sdo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, cyc + 1);
   endtask

   // Called at a negedge; the strobe lands on the next rising edge (accept edge t).
   task automatic issue(input logic [23:0] ins, input logic [15:0] adc_val, input bit accepted);
      int t;
      t        = cyc + 1;
      mux_ins  = ins;
      mux_en   = 1'b1;
      if (accepted) begin
         case (ins[23:22])
            2'b01: sw_q.push_back('{ins[21:0], t + 1 + 2*D*SW_BITS});
            2'b10: begin
               adc_word = adc_val;
               rd_q.push_back('{adc_val, t + 1 + CNV_CYCLES + 32*D});
            end
            2'b11: begin
               adc_word = adc_val;
               sw_q.push_back('{ins[21:0], t + 1 + 2*D*SW_BITS});
               rd_q.push_back('{adc_val, t + 1 + 2*D*SW_BITS + D + SETTLE_CYCLES + CNV_CYCLES + 32*D});
            end
            default: ;
         endcase
      end
      @(negedge clk);
      mux_en  = 1'b0;
      mux_ins = '0;
   endtask

   task automatic drain(input int limit);
      int n;
      n = 0;
      while ((sw_q.size() != 0 || rd_q.size() != 0 || !mux_idle) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 32'(sw_q.size() + rd_q.size()) | {31'd0, ~mux_idle}, 32'd0);
   endtask

   // Switch-chain and ADC models plus scoreboard pop; observed edge index is cyc+1.
   always @(negedge clk) begin
      if (!reset_n) begin
         sw_q.delete();
         rd_q.delete();
         sw_cap = '0; sw_cnt = 0; adc_cnt = 0; cnv_len = 0; adc_sr = '0;
         prev_sw_sclk = 1'b0; prev_sync_n = 1'b1; prev_cnv = 1'b0; prev_adc_sclk = 1'b0;
      end else begin
         if (!sw_sync_n && sw_sclk && !prev_sw_sclk) begin
            sw_cap = {sw_cap[20:0], sw_sdo};
            sw_cnt++;
         end
         if (sw_sync_n && !prev_sync_n) begin
            if (sw_q.size() == 0) begin
               check("sw_unexpected_latch", 32'd1, 32'd0);
            end else begin
               sw_exp_t e;
               e = sw_q.pop_front();
               check("sw_pattern", 32'(sw_cap), 32'(e.pat));
               check("sw_pulses", 32'(sw_cnt), 32'(SW_BITS));
               check("sw_latch_edge", 32'(cyc + 1), 32'(e.due));
            end
            sw_cap = '0;
            sw_cnt = 0;
         end

         if (adc_cnv) begin
            cnv_len++;
            adc_sr = adc_word;
         end
         if (!adc_cnv && prev_cnv) begin
            check("cnv_width", 32'(cnv_len), 32'(CNV_CYCLES));
            cnv_len = 0;
            adc_cnt = 0;
         end
         if (adc_sclk && !prev_adc_sclk) adc_cnt++;
         if (!adc_sclk && prev_adc_sclk) adc_sr = adc_sr << 1;
         adc_sdo = adc_sr[15];

         if (mux_data_ready) begin
            if (rd_q.size() == 0) begin
               check("rd_unexpected", 32'd1, 32'd0);
            end else begin
               rd_exp_t r;
               r = rd_q.pop_front();
               check("rd_data", 32'(mux_data), 32'(r.data));
               check("rd_edge", 32'(cyc + 1), 32'(r.due));
               check("rd_sclk_pulses", 32'(adc_cnt), 32'd16);
               check("rd_idle", 32'(mux_idle), 32'd1);
            end
         end

         prev_sw_sclk  = sw_sclk;
         prev_sync_n   = sw_sync_n;
         prev_cnv      = adc_cnv;
         prev_adc_sclk = adc_sclk;
      end
   end

   initial begin
      int t0;
      int quiet;
      int n;

      repeat (3) @(negedge clk);
      check("rst_idle", 32'(mux_idle), 32'd1);
      check("rst_sync_n", 32'(sw_sync_n), 32'd1);
      check("rst_sclks", 32'({sw_sclk, adc_sclk, sw_sdo, adc_cnv}), 32'd0);
      check("rst_data", 32'(mux_data), 32'd0);
      check("rst_ready_ovr", 32'({mux_data_ready, ovr}), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // NOP: no state change, no serial activity
      issue(24'h000000, 16'h0, 1'b1);
      quiet = 0;
      repeat (20) begin
         if (!mux_idle || sw_sclk || adc_sclk || !sw_sync_n || adc_cnv) quiet++;
         @(negedge clk);
      end
      check("nop_quiet", 32'(quiet), 32'd0);

      // CONNECT with alternating pattern
      t0 = cyc + 1;
      issue(24'h6AAAAA, 16'h0, 1'b1);
      check("connect_busy", 32'(mux_idle), 32'd0);
      n = 0;
      while (!mux_idle && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("connect_idle_edge", 32'(cyc + 1), 32'(t0 + 1 + 2*D*SW_BITS + D));
      drain(100);

      // MEASURE
      issue(24'h800000, 16'hBEEF, 1'b1);
      drain(1000);
      repeat (10) @(negedge clk);
      check("data_hold", 32'(mux_data), 32'h0000BEEF);

      // CONNECT_MEASURE
      issue(24'hC00001, 16'h0001, 1'b1);
      drain(2000);
      check("cm_data", 32'(mux_data), 32'h00000001);

      // Back-to-back MEASURE, second strobe in the DONE cycle
      issue(24'h800000, 16'h1234, 1'b1);
      n = 0;
      while (!mux_data_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("b2b_first_ready", 32'(mux_data_ready), 32'd1);
      issue(24'h800000, 16'h5A5A, 1'b1);
      check("b2b_cnv_rise", 32'(adc_cnv), 32'd1);
      check("b2b_busy", 32'(mux_idle), 32'd0);
      drain(1000);
      check("b2b_no_ovr", 32'(ovr), 32'd0);

      // Overrun: second strobe 10 cycles after a CONNECT accept
      issue(24'h400F0F, 16'h0, 1'b1);
      repeat (9) @(negedge clk);
      issue(24'h800000, 16'hFFFF, 1'b0);
      check("ovr_set", 32'(ovr), 32'd1);
      drain(1000);
      repeat (5) @(negedge clk);
      check("ovr_sticky", 32'(ovr), 32'd1);
      check("ovr_data_kept", 32'(mux_data), 32'h00005A5A);

      // Reset in the middle of SW_SHIFT
      issue(24'h7FFFFF, 16'h0, 1'b1);
      repeat (20) @(negedge clk);
      check("mid_shift_active", 32'(sw_sync_n), 32'd0);
      reset_n = 1'b0;
      @(negedge clk);
      check("mrst_sync_n", 32'(sw_sync_n), 32'd1);
      check("mrst_sclk", 32'({sw_sclk, adc_sclk}), 32'd0);
      check("mrst_idle", 32'(mux_idle), 32'd1);
      check("mrst_ovr", 32'(ovr), 32'd0);
      check("mrst_data", 32'(mux_data), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Recovery after reset
      issue(24'h800000, 16'hA5C3, 1'b1);
      drain(1000);
      check("recover_data", 32'(mux_data), 32'h0000A5C3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mux_ctrl.md
Name: mux_ctrl

Overview:
- Downstream consumer of the instruction-fetch/decode stage's 24-bit MUX instruction port.
- Executes CONNECT (serially loads the crossbar switch-chip chain), MEASURE (triggers and reads a 16-bit SPI ADC) or CONNECT_MEASURE.
- Returns ADC results on the 16-bit mux_data/ready port that feeds the direct-data path.
- Reports busy/idle status back upstream.

Parameters:
- SW_BITS, 22: length of the switch-chip shift chain in bits.
- SCLK_DIV, 4: half-period of sw_sclk_o and adc_sclk_o, in fpga_clk_i cycles (>=1).
- CNV_CYCLES, 100: adc_cnv_o high time, in cycles (>=1).
- SETTLE_CYCLES, 50: wait between switch latch and conversion start in CONNECT_MEASURE (>=1).

Ports:
- fpga_clk_i  in  1  100 MHz system clock.
- reset_n_i  in  1  synchronous active-low reset.
- mux_ins_i  in  24  instruction word. [23:22] cmd: 00 NOP, 01 CONNECT, 10 MEASURE, 11 CONNECT_MEASURE. [21:0] switch pattern, shifted MSB first.
- mux_en_i  in  1  one-cycle instruction strobe.
- mux_idle_o  out  1  high when ready to accept an instruction.
- mux_data_ready_o  out  1  one-cycle result-valid pulse.
- mux_data_o  out  16  last ADC result.
- ovr_o  out  1  sticky flag: strobe received while busy.
- sw_sclk_o  out  1  switch-chain serial clock.
- sw_sdo_o  out  1  switch-chain serial data.
- sw_sync_n_o  out  1  switch-chain frame/latch, active low.
- adc_cnv_o  out  1  ADC conversion start.
- adc_sclk_o  out  1  ADC serial clock.
- adc_sdo_i  in  1  ADC serial data.

Behaviour:
- One clock domain (fpga_clk_i, rising edge). Synchronous, active-low reset.
- Reset values, applied on the first rising edge with reset_n_i=0, including mid-operation (any state aborts to IDLE):
  - mux_idle_o=1, ovr_o=0, sw_sync_n_o=1, adc_cnv_o=0.
  - mux_data_ready_o=0, mux_data_o=0.
  - sw_sclk_o=0, sw_sdo_o=0, adc_sclk_o=0.
- Accept:
  - At edge T, the block accepts if mux_en_i=1 and it is in IDLE. The instruction is latched internally at T.
  - cmd NOP: no state change, mux_idle_o stays 1.
  - Any other cmd: mux_idle_o=0 from T+1.
  - mux_en_i=1 while busy is ignored; ovr_o set at the next edge and cleared only by reset.
- FSM states: IDLE, SW_SHIFT, SW_LATCH, SETTLE, CNV, ADC_SHIFT, DONE.
- SW_SHIFT (CONNECT and CONNECT_MEASURE):
  - Entered at T+1: sw_sync_n_o=0, sw_sdo_o=pattern[SW_BITS-1].
  - Each bit: sw_sclk_o low for SCLK_DIV cycles, then high for SCLK_DIV cycles.
  - sw_sdo_o changes only when sw_sclk_o goes low, so data is stable across the rising edge.
  - Pattern bits [SW_BITS-1:0] are shifted MSB first; bit i is shifted as pattern[i].
- SW_LATCH:
  - sw_sclk_o=0, sw_sync_n_o=1 for SCLK_DIV cycles.
  - Then CONNECT goes to IDLE; CONNECT_MEASURE goes to SETTLE.
- SETTLE: all serial outputs idle for SETTLE_CYCLES cycles, then CNV.
- CNV:
  - MEASURE enters CNV at T+1.
  - adc_cnv_o=1 for CNV_CYCLES cycles, then 0.
- ADC_SHIFT:
  - 16 bits, same sclk timing as SW_SHIFT, MSB first.
  - adc_sdo_i is sampled on the last cycle of each sclk-high phase and shifted into a 16-bit shift register.
- DONE:
  - Single cycle: mux_data_o <= shift register, mux_data_ready_o=1, mux_idle_o=1.
  - Next state IDLE.
  - A new mux_en_i is accepted in the DONE cycle.
  - mux_data_o holds its value until the next DONE or reset.
- Latencies, with accept at edge T (D=SCLK_DIV):
  - CONNECT: mux_idle_o back to 1 at T+1+2*D*SW_BITS+D.
  - MEASURE: ready pulse and idle at T+1+CNV_CYCLES+32*D.
  - CONNECT_MEASURE: ready pulse at T+1+2*D*SW_BITS+D+SETTLE_CYCLES+CNV_CYCLES+32*D.
- Serial clocks are low in every state other than SW_SHIFT and ADC_SHIFT. No sclk glitch on state transitions.
- Counters:
  - Bit counter: 5 bits, must cover SW_BITS and 16.
  - Phase counter: covers SCLK_DIV.
  - Delay counter: 16 bits, covers CNV_CYCLES and SETTLE_CYCLES.
  - Counters reload on state entry; no wrap-around occurs within a state.

Test Plan:
- Reset: hold reset_n_i=0 for 3 cycles mid-SW_SHIFT → next edge sw_sync_n_o=1, sclk=0, mux_idle_o=1, ovr_o=0, mux_data_o=0.
- CONNECT, mux_ins_i=0x6AAAAA, defaults → 22 sclk pulses; captured bits alternate 1,0,… ending 0; sw_sync_n_o rises; mux_idle_o=1 at T+181.
- MEASURE, mux_ins_i=0x800000, ADC model returns 0xBEEF → adc_cnv_o high 100 cycles; 16 sclk pulses; mux_data_ready_o pulse with mux_data_o=0xBEEF at T+229; mux_data_o holds 0xBEEF afterwards.
- CONNECT_MEASURE, mux_ins_i=0xC00001, ADC returns 0x0001 → last switch bit=1, others 0; ready pulse at T+181+50+100+128=T+459 with data 0x0001.
- Overrun: second mux_en_i 10 cycles after a CONNECT accept → instruction ignored, ovr_o=1, first transfer unaffected, ovr_o stays 1 after completion.
- NOP (0x000000) and back-to-back: NOP keeps mux_idle_o=1 with no serial activity; MEASURE strobe in the DONE cycle of a prior MEASURE is accepted, adc_cnv_o rises at the next edge.
